// File: rtl/key_conditioner_if.sv
// Pushbutton bundle between the raw KEY pins, the key conditioner and the stopwatch core.
// slave = conditioner side, master = board/consumer side.
interface key_conditioner_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;

    modport master (
        output KEY,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  KEY,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_conditioner.sv
// Synchronises, debounces and edge-detects active-low pushbuttons into clean strobes.
// Define KEY_LONG_PRESS_EN to add a one-shot long-hold pulse per key on key_long.
module key_conditioner #(
    parameter int unsigned N_KEYS      = 4,
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input logic              CLOCK_50,
    input logic              reset_n,
    key_conditioner_if.slave keys
);
    localparam int unsigned DB_CYCLES   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned LONG_CYCLES = CLK_HZ / 1000 * LONG_MS;
    localparam int unsigned DB_W        = $clog2(DB_CYCLES + 1);

    if (DB_CYCLES < 1) begin : g_bad_db
        $error("key_conditioner: debounce period is shorter than one clock cycle");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("key_conditioner: long-press period is shorter than one clock cycle");
    end

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } key_state_e;

    key_state_e        state_q [N_KEYS];
    logic [DB_W-1:0]   cnt_q   [N_KEYS];
    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [N_KEYS-1:0] level_q, press_q, release_q;
    logic [N_KEYS-1:0] pressed;

    // Synchronised and inverted: 1 = button held down.
    assign pressed = ~sync2_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= StReleased;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= keys.KEY;
            sync2_q   <= sync1_q;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                unique case (state_q[i])
                    StReleased: begin
                        if (pressed[i]) begin
                            state_q[i] <= StPressWait;
                            cnt_q[i]   <= DB_W'(1);
                        end
                    end
                    StPressWait: begin
                        if (!pressed[i]) begin
                            state_q[i] <= StReleased;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == DB_W'(DB_CYCLES)) begin
                            state_q[i] <= StPressed;
                            cnt_q[i]   <= '0;
                            level_q[i] <= 1'b1;
                            press_q[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + DB_W'(1);
                        end
                    end
                    StPressed: begin
                        if (!pressed[i]) begin
                            state_q[i] <= StReleaseWait;
                            cnt_q[i]   <= DB_W'(1);
                        end
                    end
                    StReleaseWait: begin
                        if (pressed[i]) begin
                            state_q[i] <= StPressed;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == DB_W'(DB_CYCLES)) begin
                            state_q[i]   <= StReleased;
                            cnt_q[i]     <= '0;
                            level_q[i]   <= 1'b0;
                            release_q[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + DB_W'(1);
                        end
                    end
                    default: begin
                        state_q[i] <= StReleased;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign keys.key_level   = level_q;
    assign keys.key_press   = press_q;
    assign keys.key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);

    logic [LONG_W-1:0] hold_q [N_KEYS];
    logic [N_KEYS-1:0] long_q;

    // Counts only while settled in StPressed; any exit clears it, so re-entry restarts.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            long_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            long_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                if (state_q[i] == StPressed && pressed[i]) begin
                    if (hold_q[i] != LONG_W'(LONG_CYCLES)) begin
                        hold_q[i] <= hold_q[i] + LONG_W'(1);
                        if (hold_q[i] == LONG_W'(LONG_CYCLES - 1)) begin
                            long_q[i] <= 1'b1;
                        end
                    end
                end else begin
                    hold_q[i] <= '0;
                end
            end
        end
    end

    assign keys.key_long = long_q;
`else
    assign keys.key_long = '0;
`endif
endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DB_CYCLES=4, LONG_CYCLES=10.
// Expected pulse events are queued with their cycle number and checked as the DUT emits them.
module tb_key_conditioner;
    localparam int unsigned N_KEYS = 4;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } ev_t;

    logic CLOCK_50 = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   base = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  sb[$];
    ev_t  mon_e;

    key_conditioner_if #(.N_KEYS(N_KEYS)) keys ();

    key_conditioner #(
        .N_KEYS     (N_KEYS),
        .CLK_HZ     (1000),
        .DEBOUNCE_MS(4),
        .LONG_MS    (10)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .keys    (keys)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Cycle k = the period after posedge k; edge 0 is the first edge sampling new stimulus.
    function automatic int rel();
        return cyc - base - 1;
    endfunction

    task automatic wait_rel(input int n);
        while (rel() < n) @(negedge CLOCK_50);
    endtask

    task automatic start(input logic [3:0] k);
        @(negedge CLOCK_50);
        keys.KEY = k;
        base     = cyc;
    endtask

    task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l);
        ev_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.lng   = l;
        sb.push_back(e);
    endtask

    task automatic check_level(input string tag, input logic [3:0] exp);
        check_eq(tag, {28'b0, keys.key_level}, {28'b0, exp});
    endtask

    task automatic reset_idle();
        @(negedge CLOCK_50);
        reset_n  = 1'b0;
        keys.KEY = 4'b1111;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check_eq("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge CLOCK_50) begin
        if ((keys.key_press | keys.key_release | keys.key_long) != 4'b0000) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse",
                         {20'b0, keys.key_press, keys.key_release, keys.key_long}, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("pulse_cycle", rel(), mon_e.cyc);
                check_eq("pulse_vec", {20'b0, keys.key_press, keys.key_release, keys.key_long},
                         {20'b0, mon_e.press, mon_e.rel, mon_e.lng});
            end
        end
    end

    initial begin
        keys.KEY = 4'b0000;
        reset_n  = 1'b0;

        // Outputs held at zero during reset, then a key held through reset release.
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK_50);
            check_level("rst_level", 4'b0000);
            check_eq("rst_pulses", {20'b0, keys.key_press, keys.key_release, keys.key_long}, 0);
        end
        keys.KEY = 4'b1110;
        reset_n  = 1'b1;
        base     = cyc;
        push_ev(6, 4'b0001, 4'b0000, 4'b0000);
        wait_rel(5);
        check_level("s1_lvl_before", 4'b0000);
        wait_rel(12);
        check_level("s1_lvl_after", 4'b0001);
        reset_idle();

        // Press then release with exact latency and level tracking.
        start(4'b1110);
        push_ev(6, 4'b0001, 4'b0000, 4'b0000);
        push_ev(26, 4'b0000, 4'b0001, 4'b0000);
        wait_rel(5);
        check_level("s2_lvl_c5", 4'b0000);
        wait_rel(6);
        check_level("s2_lvl_c6", 4'b0001);
        wait_rel(19);
        keys.KEY = 4'b1111;
        wait_rel(25);
        check_level("s2_lvl_c25", 4'b0001);
        wait_rel(26);
        check_level("s2_lvl_c26", 4'b0000);
        wait_rel(32);
        reset_idle();

        // Bouncy KEY[1]: low3/high1/low3 must be rejected.
        start(4'b1101);
        wait_rel(2);
        keys.KEY = 4'b1111;
        wait_rel(3);
        keys.KEY = 4'b1101;
        wait_rel(6);
        keys.KEY = 4'b1111;
        wait_rel(15);
        check_level("s3_bounce_lvl", 4'b0000);

        // Boundary: 4 low samples rejected, 5 accepted.
        start(4'b1101);
        wait_rel(3);
        keys.KEY = 4'b1111;
        wait_rel(14);
        check_level("s3_four_lvl", 4'b0000);
        start(4'b1101);
        push_ev(6, 4'b0010, 4'b0000, 4'b0000);
        push_ev(11, 4'b0000, 4'b0010, 4'b0000);
        wait_rel(4);
        keys.KEY = 4'b1111;
        wait_rel(6);
        check_level("s3_five_lvl", 4'b0010);
        wait_rel(16);
        check_level("s3_five_end", 4'b0000);
        reset_idle();

        // Simultaneous KEY[0] and KEY[2].
        start(4'b1010);
        push_ev(6, 4'b0101, 4'b0000, 4'b0000);
        push_ev(16, 4'b0000, 4'b0101, 4'b0000);
        wait_rel(7);
        check_level("s4_lvl_held", 4'b0101);
        wait_rel(9);
        keys.KEY = 4'b1111;
        wait_rel(20);
        check_level("s4_lvl_end", 4'b0000);
        reset_idle();

        // Long hold on KEY[3]: one key_long only when the feature is built in.
        start(4'b0111);
        push_ev(6, 4'b1000, 4'b0000, 4'b0000);
`ifdef KEY_LONG_PRESS_EN
        push_ev(16, 4'b0000, 4'b0000, 4'b1000);
`endif
        push_ev(36, 4'b0000, 4'b1000, 4'b0000);
        wait_rel(29);
        keys.KEY = 4'b1111;
        wait_rel(31);
        check_level("s5_lvl_held", 4'b1000);
        wait_rel(40);
        check_level("s5_lvl_end", 4'b0000);
        reset_idle();

        // Reset mid debounce discards progress; full debounce after release.
        start(4'b1011);
        wait_rel(4);
        reset_n = 1'b0;
        #1;
        check_eq("s6_rst_pulses", {20'b0, keys.key_press, keys.key_release, keys.key_long}, 0);
        wait_rel(5);
        reset_n = 1'b1;
        base    = cyc;
        push_ev(6, 4'b0100, 4'b0000, 4'b0000);
        wait_rel(5);
        check_level("s6_lvl_c5", 4'b0000);
        wait_rel(12);
        check_level("s6_lvl_c12", 4'b0100);
        reset_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
